mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 18 +
 rtl/mul_div_unit.sv | 119 +++++++++++
 tb/tb_mul_div_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: way encodings and latencies.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {IDLE, RUN} mdu_state_e;

  function automatic logic way_valid(input logic [2:0] w);
    return (w == MDU_MULT) || (w == MDU_MULTU) || (w == MDU_DIV) || (w == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with mthi/mtlo.
// Macro MDU_DIVZERO_KEEP_EN: divide by zero leaves HI/LO unchanged instead of writing dividend/all-ones.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  way,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;

  logic        accept;
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod;
  logic [31:0] abs_a, abs_b, div_s, div_u, q_mag, r_mag;

  assign accept = start && !req && (state_q == IDLE) && way_valid(way);

  // Result is a pure function of the latched operands; it is only sampled at completion.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    prod  = 64'd0;
    abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
    div_s = (b_q == 32'd0) ? 32'd1 : abs_b;
    div_u = (b_q == 32'd0) ? 32'd1 : b_q;
    q_mag = abs_a / div_s;
    r_mag = abs_a % div_s;
    case (op_q)
      MDU_MULT: begin
        prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        {hi_d, lo_d} = prod;
      end
      MDU_MULTU: begin
        prod = {32'd0, a_q} * {32'd0, b_q};
        {hi_d, lo_d} = prod;
      end
      MDU_DIV, MDU_DIVU: begin
        if (b_q == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
          hi_d = hi_q;
          lo_d = lo_q;
`else
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
`endif
        end else if (op_q == MDU_DIVU) begin
          lo_d = a_q / div_u;
          hi_d = a_q % div_u;
        end else begin
          // Magnitude divide then fix signs; 0x80000000 / -1 wraps to 0x80000000 naturally.
          lo_d = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
          hi_d = a_q[31] ? (32'd0 - r_mag) : r_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req && hi_we) hi_q <= rs_data;
          if (!req && lo_we) lo_q <= rs_data;
          if (accept) begin
            a_q     <= rs_data;
            b_q     <= rt_data;
            op_q    <= way;
            cnt_q   <= ((way == MDU_MULT) || (way == MDU_MULTU)) ? MULT_CYCLES : DIV_CYCLES;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == 4'd1) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= 4'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  way = 3'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi_out, lo_out;

  int vecs = 0;
  int errs = 0;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  mul_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .way(way),
    .hi_we(hi_we), .lo_we(lo_we), .rs_data(rs_data), .rt_data(rt_data),
    .req(req), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules; returns {HI,LO}.
  function automatic logic [63:0] model(input logic [2:0] w, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (w)
      3'd1: begin p = longint'(sa) * longint'(sb); return p; end
      3'd2: return 64'(a) * 64'(b);
      3'd3, 3'd4: begin
        if (b == 0) begin
`ifdef MDU_DIVZERO_KEEP_EN
          return {hi, lo};
`else
          return {a, 32'hFFFF_FFFF};
`endif
        end
        if (w == 3'd4) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] w, input logic [31:0] a, input logic [31:0] b);
    int n;
    int exp_n;
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1; way = w; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; way = 3'd0;
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    exp_n = (w == 3'd1 || w == 3'd2) ? 5 : 10;
    r = model(w, a, b, hi_m, lo_m);
    {hi_m, lo_m} = r;
    chk({tag, "_busy"}, 64'(n), 64'(exp_n));
    chk({tag, "_hilo"}, {hi_out, lo_out}, {hi_m, lo_m});
  endtask

  initial begin
    logic [2:0]  w;
    logic [31:0] a, b;

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'h2);
    chk("mult_neg_abs", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h2);
    chk("multu_abs", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h2);
    chk("div_neg_abs", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2);
    chk("divu_abs", {hi_out, lo_out}, {32'd1, 32'd3});
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_abs", {hi_out, lo_out}, {32'd0, 32'h8000_0000});

    // Preload HI/LO, then divide by zero.
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    hi_m = 32'h1234_5678; lo_m = 32'h1234_5678;
    chk("mthilo", {hi_out, lo_out}, {hi_m, lo_m});
    run_op("divzero", 3'd3, 32'd5, 32'd0);
`ifdef MDU_DIVZERO_KEEP_EN
    chk("divzero_abs", {hi_out, lo_out}, {32'h1234_5678, 32'h1234_5678});
`else
    chk("divzero_abs", {hi_out, lo_out}, {32'd5, 32'hFFFF_FFFF});
`endif

    // Flush suppresses start and mthi/mtlo.
    @(negedge clk);
    start = 1'b1; way = 3'd1; req = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
    rs_data = 32'hDEAD_BEEF; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0; req = 1'b0; hi_we = 1'b0; lo_we = 1'b0; way = 3'd0;
    chk("req_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("req_hilo", {hi_out, lo_out}, {hi_m, lo_m});

    // Invalid way codes are no-ops.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; way = (i == 0) ? 3'd0 : 3'(4 + i); rs_data = 32'd9; rt_data = 32'd9;
      @(negedge clk);
      start = 1'b0; way = 3'd0;
      chk("badway_busy", 64'(busy), 64'd0);
    end
    chk("badway_hilo", {hi_out, lo_out}, {hi_m, lo_m});

    // mthi and a second start while busy are ignored.
    @(negedge clk);
    start = 1'b1; way = 3'd2; rs_data = 32'd100; rt_data = 32'd200;
    @(negedge clk);
    start = 1'b1; way = 3'd3; hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'hAAAA_5555; rt_data = 32'd1;
    @(negedge clk);
    start = 1'b0; way = 3'd0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (4) @(negedge clk);
    chk("inflight_busy_fell", 64'(busy), 64'd0);
    chk("inflight_hilo", {hi_out, lo_out}, {32'd0, 32'd20000});
    {hi_m, lo_m} = {32'd0, 32'd20000};

    // Reset at busy cycle 3 of a mult.
    @(negedge clk);
    start = 1'b1; way = 3'd1; rs_data = 32'd12345; rt_data = 32'd6789;
    @(negedge clk);
    start = 1'b0; way = 3'd0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_hilo", {hi_out, lo_out}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;

    // Start accepted in the first cycle after reset release.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; start = 1'b1; way = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; way = 3'd0;
    chk("first_cycle_start", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    chk("first_cycle_hilo", {hi_out, lo_out}, {32'd2, 32'd14});
    {hi_m, lo_m} = {32'd2, 32'd14};

    for (int i = 0; i < 40; i++) begin
      w = 3'($urandom_range(1, 4));
      a = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom();
      endcase
      run_op("rand", w, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
